// File: rtl/bsg_bit_scan_pkg.sv
// ============================================================================
// Module   : bsg_bit_scan_pkg
// Purpose  : Shared elaboration helpers for the bit-scan serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bsg_bit_scan_pkg;

    localparam int C_MIN_WIDTH = 2;
    localparam int C_MAX_WIDTH = 1024;

    function automatic bit bsg_width_ok(input int width);
        return (width >= C_MIN_WIDTH) && (width <= C_MAX_WIDTH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_scan_first_one.sv
// ============================================================================
// Module   : bsg_scan_first_one
// Purpose  : Log-depth priority scan returning one-hot, index and found flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_scan_first_one
    import bsg_bit_scan_pkg::*;
#(
    parameter  int width_p      = 64,
    parameter  int lsb_first_p  = 1,
    localparam int idx_width_lp = $clog2(width_p)
) (
    input  logic [width_p-1:0]      data,
    output logic [width_p-1:0]      one_hot,
    output logic [idx_width_lp-1:0] idx,
    output logic                    found
);

    localparam int                    C_LEAVES = 1 << idx_width_lp;
    localparam logic [idx_width_lp-1:0] C_TOP  = idx_width_lp'(width_p - 1);

    logic [width_p-1:0]       scan_in;
    logic [2*C_LEAVES-1:1]    node_found;
    logic [idx_width_lp-1:0]  node_idx [1:2*C_LEAVES-1];

    // MSB-first scans the bit-reversed vector and maps the index back.
    if (lsb_first_p != 0) begin : g_order_lsb
        assign scan_in = data;
    end else begin : g_order_msb
        for (genvar i = 0; i < width_p; i++) begin : g_rev
            assign scan_in[i] = data[width_p-1-i];
        end
    end

    for (genvar i = 0; i < C_LEAVES; i++) begin : g_leaf
        if (i < width_p) begin : g_real
            assign node_found[C_LEAVES+i] = scan_in[i];
        end else begin : g_pad
            assign node_found[C_LEAVES+i] = 1'b0;
        end
        assign node_idx[C_LEAVES+i] = idx_width_lp'(i);
    end

    // Heap-ordered tree: node k has children 2k (lower indices) and 2k+1.
    for (genvar k = 1; k < C_LEAVES; k++) begin : g_node
        assign node_found[k] = node_found[2*k] | node_found[2*k+1];
        assign node_idx[k]   = node_found[2*k] ? node_idx[2*k] : node_idx[2*k+1];
    end

    assign found = node_found[1];

    if (lsb_first_p != 0) begin : g_idx_lsb
        assign idx = found ? node_idx[1] : '0;
    end else begin : g_idx_msb
        assign idx = found ? (C_TOP - node_idx[1]) : '0;
    end

    for (genvar i = 0; i < width_p; i++) begin : g_one_hot
        assign one_hot[i] = found & (idx == idx_width_lp'(i));
    end

endmodule

`default_nettype wire

// File: rtl/bsg_bit_scan_serializer.sv
// ============================================================================
// Module   : bsg_bit_scan_serializer
// Purpose  : Serialises a request bit-vector into a stream of set-bit indices.
//            Optional all-zero beat: define BSG_BIT_SCAN_SERIALIZER_EMPTY_BEAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_bit_scan_serializer
    import bsg_bit_scan_pkg::*;
#(
    parameter  int width_p      = 64,
    parameter  int lsb_first_p  = 1,
    localparam int idx_width_lp = $clog2(width_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [width_p-1:0]      data_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [idx_width_lp-1:0] idx_o,
    output logic                    last_o,
    output logic                    empty_o,
    output logic                    v_o,
    input  logic                    yumi_i
);

    if (!bsg_width_ok(width_p)) begin : g_width_check
        $error("bsg_bit_scan_serializer: width_p out of range 2..1024");
    end

    logic [width_p-1:0]      pend_r;
    logic [width_p-1:0]      sel_one_hot;
    logic [idx_width_lp-1:0] sel_idx;
    logic                    sel_found;
    logic [width_p-1:0]      rest;
    logic                    zero_hold;
    logic                    load;

    bsg_scan_first_one #(
        .width_p     (width_p),
        .lsb_first_p (lsb_first_p)
    ) u_scan (
        .data    (pend_r),
        .one_hot (sel_one_hot),
        .idx     (sel_idx),
        .found   (sel_found)
    );

    assign rest = pend_r & ~sel_one_hot;

`ifdef BSG_BIT_SCAN_SERIALIZER_EMPTY_BEAT_EN
    logic zero_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            zero_r <= 1'b0;
        end else if (load) begin
            zero_r <= (data_i == '0);
        end else if (yumi_i) begin
            zero_r <= 1'b0;
        end
    end

    assign zero_hold = zero_r;
    assign empty_o   = ~reset_i & zero_r;
`else
    assign zero_hold = 1'b0;
    assign empty_o   = 1'b0;
`endif

    // Outputs are forced idle while reset is high, before pend_r has cleared.
    assign v_o     = ~reset_i & (sel_found | zero_hold);
    assign idx_o   = reset_i ? '0 : sel_idx;
    assign last_o  = v_o & (rest == '0);
    assign ready_o = ~reset_i & (~v_o | (yumi_i & last_o));
    assign load    = v_i & ready_o;

    // A reload wins over the clear from a simultaneous final pop.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_r <= '0;
        end else if (load) begin
            pend_r <= data_i;
        end else if (yumi_i) begin
            pend_r <= rest;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!yumi_i || v_o)
                else $error("bsg_bit_scan_serializer: yumi_i asserted while v_o=0");
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bsg_bit_scan_serializer.sv
// ============================================================================
// Module   : tb_bsg_bit_scan_serializer
// Purpose  : Directed self-checking bench; LSB-first and MSB-first instances.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_bit_scan_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] data;
    logic        v_in;
    logic        yumi;

    logic        a_ready, a_last, a_empty, a_v;
    logic [5:0]  a_idx;
    logic        b_ready, b_last, b_empty, b_v;
    logic [5:0]  b_idx;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bsg_bit_scan_serializer #(.width_p(64), .lsb_first_p(1)) dut_lsb (
        .clk_i   (clk),
        .reset_i (reset),
        .data_i  (data),
        .v_i     (v_in),
        .ready_o (a_ready),
        .idx_o   (a_idx),
        .last_o  (a_last),
        .empty_o (a_empty),
        .v_o     (a_v),
        .yumi_i  (yumi)
    );

    bsg_bit_scan_serializer #(.width_p(64), .lsb_first_p(0)) dut_msb (
        .clk_i   (clk),
        .reset_i (reset),
        .data_i  (data),
        .v_i     (v_in),
        .ready_o (b_ready),
        .idx_o   (b_idx),
        .last_o  (b_last),
        .empty_o (b_empty),
        .v_o     (b_v),
        .yumi_i  (yumi)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks land mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1;
        data  = '0;
        v_in  = 1'b0;
        yumi  = 1'b0;

        // Reset held for two cycles, then idle.
        step(); settle();
        check("rst_v", a_v, 0);
        check("rst_ready", a_ready, 0);
        step(); settle();
        check("rst_v2", a_v, 0);
        check("rst_ready2", a_ready, 0);
        check("rst_idx", a_idx, 0);
        check("rst_last", a_last, 0);
        check("rst_empty", a_empty, 0);
        reset = 1'b0;
        settle();
        check("idle_ready", a_ready, 1);
        check("idle_v", a_v, 0);
        check("idle_ready_msb", b_ready, 1);

        // Three-bit vector, consumer always ready.
        step();
        data = 64'h8000_0000_0000_0011;
        v_in = 1'b1;
        settle();
        check("ld_ready", a_ready, 1);
        step();
        v_in = 1'b0;
        yumi = 1'b1;
        settle();
        check("seq_v0", a_v, 1);
        check("seq_i0", a_idx, 0);
        check("seq_l0", a_last, 0);
        check("seq_ready0", a_ready, 0);
        check("msb_i0", b_idx, 63);
        check("msb_l0", b_last, 0);
        step(); settle();
        check("seq_i1", a_idx, 4);
        check("seq_l1", a_last, 0);
        check("msb_i1", b_idx, 4);
        step(); settle();
        check("seq_i2", a_idx, 63);
        check("seq_l2", a_last, 1);
        check("seq_ready2", a_ready, 1);
        check("msb_i2", b_idx, 0);
        check("msb_l2", b_last, 1);
        step();
        yumi = 1'b0;
        settle();
        check("seq_done_v", a_v, 0);
        check("msb_done_v", b_v, 0);

        // Backpressure holds the current index.
        data = 64'h6;
        v_in = 1'b1;
        step();
        v_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("bp_v", a_v, 1);
            check("bp_idx", a_idx, 1);
            check("bp_ready", a_ready, 0);
            check("bp_msb_idx", b_idx, 2);
            step();
        end
        yumi = 1'b1;
        settle();
        check("bp_pop_i0", a_idx, 1);
        check("bp_pop_l0", a_last, 0);
        step(); settle();
        check("bp_pop_i1", a_idx, 2);
        check("bp_pop_l1", a_last, 1);
        step();
        yumi = 1'b0;
        settle();
        check("bp_done_v", a_v, 0);

        // Back-to-back reloads without bubbles.
        data = 64'h1;
        v_in = 1'b1;
        settle();
        check("b2b_ready0", a_ready, 1);
        step();
        data = 64'h2;
        yumi = 1'b1;
        settle();
        check("b2b_v0", a_v, 1);
        check("b2b_i0", a_idx, 0);
        check("b2b_l0", a_last, 1);
        check("b2b_ready1", a_ready, 1);
        step();
        data = 64'h1C;
        settle();
        check("b2b_v1", a_v, 1);
        check("b2b_i1", a_idx, 1);
        check("b2b_ready2", a_ready, 1);
        step();
        v_in = 1'b0;
        yumi = 1'b0;
        settle();
        check("b2b_i2", a_idx, 2);
        check("b2b_l2", a_last, 0);
        reset = 1'b1;
        step(); settle();
        check("midrst_v", a_v, 0);
        check("midrst_ready", a_ready, 0);
        reset = 1'b0;
        settle();
        check("postrst_v", a_v, 0);
        check("postrst_ready", a_ready, 1);

        // All-zero vector.
        data = 64'h0;
        v_in = 1'b1;
        settle();
        check("zero_ready", a_ready, 1);
        step();
        v_in = 1'b0;
        settle();
`ifdef BSG_BIT_SCAN_SERIALIZER_EMPTY_BEAT_EN
        check("zero_v", a_v, 1);
        check("zero_empty", a_empty, 1);
        check("zero_last", a_last, 1);
        check("zero_idx", a_idx, 0);
        check("zero_msb_empty", b_empty, 1);
        yumi = 1'b1;
        settle();
        check("zero_pop_ready", a_ready, 1);
        step();
        yumi = 1'b0;
        settle();
        check("zero_done_v", a_v, 0);
        check("zero_done_empty", a_empty, 0);
`else
        check("zero_v", a_v, 0);
        check("zero_ready_after", a_ready, 1);
        check("zero_empty", a_empty, 0);
        check("zero_msb_v", b_v, 0);
`endif

        // Full vector: every index in order.
        data = 64'hFFFF_FFFF_FFFF_FFFF;
        v_in = 1'b1;
        step();
        v_in = 1'b0;
        yumi = 1'b1;
        for (int i = 0; i < 64; i++) begin
            settle();
            check("full_v", a_v, 1);
            check("full_idx", a_idx, 64'(i));
            check("full_last", a_last, (i == 63) ? 64'd1 : 64'd0);
            check("full_msb_idx", b_idx, 64'(63 - i));
            step();
        end
        yumi = 1'b0;
        settle();
        check("full_done_v", a_v, 0);
        check("full_done_ready", a_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
